instruction_queue: RTL and testbench
====================================

// Module: instruction_queue
// PURPOSE
//  Circular FIFO that buffers compacted decode packets. It sits directly downstream of the
//  4-lane compaction stage and accepts up to 4 ops per cycle. Ops are packed into lanes A..D
//  with no gaps. It presents the 2 oldest ops to issue, which can pop 0-2 per cycle.
//  It decouples the front-end burst width from issue width and supports a pipeline flush.
// PARAMETERS
//  WIDTH  57  bits per op (matches the compacted op format)
//  DEPTH  16  entries; power of 2, >= 8; PTR_W = log2(DEPTH), CNT_W = PTR_W+1
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  flush        in   1      sync discard of all entries (mispredict/exception)
//  in_op_a..d   in   WIDTH  compacted ops, lane A = oldest
//  in_valid_a..d in  1      lane valids; must be contiguous from A (A, AB, ABC, ABCD)
//  in_ready     out  1      1 = at least 4 free slots; write is taken this cycle
//  out_op_a     out  WIDTH  oldest entry (mem[head])
//  out_valid_a  out  1      count >= 1
//  out_op_b     out  WIDTH  second-oldest entry (mem[head+1])
//  out_valid_b  out  1      count >= 2
//  out_accept_a in   1      issue pops entry A this cycle
//  out_accept_b in   1      issue pops entry B; honoured only with out_accept_a
//  count        out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (async, rst_n=0): head=tail=count=0 immediately.
//    Outputs: in_ready=1, out_valid_a/b=0, count=0. Memory is not reset.
//  - in_ready = (DEPTH-count) >= 4, combinational from registered count.
//    It ignores any pop in the same cycle.
//  - enq_n = number of leading 1s in {A,B,C,D} valids. A valid lane after a gap is ignored.
//    Simulation assertion fires on a gap.
//  - Enqueue when in_ready: lane i (i < enq_n) is written to mem[(tail+i) mod DEPTH].
//    tail += enq_n. Pointers wrap modulo DEPTH.
//  - Valids while in_ready=0 are dropped with no state change. Upstream holds its packet.
//  - deq_n = accept_a&valid_a ? (1 + (accept_b&valid_b)) : 0. head += deq_n.
//  - Accepts without the matching valid are ignored. accept_b without accept_a is ignored.
//  - count_next = count + enq_n - deq_n. Same-cycle enq+deq both apply.
//  - A write never targets a slot being read: in_ready guarantees >= 4 free slots.
//  - Read latency: an op enqueued in cycle N is visible on out_op_a no earlier than N+1.
//    There is no same-cycle bypass.
//  - out_op_a/b are driven from memory regardless of valid. Their value is don't-care
//    when the matching valid=0.
//  - flush=1: next edge sets head=tail=count=0. It overrides a same-cycle enq/deq.
//  - Full (count=DEPTH): out_valid_a/b=1, in_ready=0.
//  - Empty (count=0): out_valid_a/b=0, in_ready=1.
//  - rst_n asserted mid-burst: state clears asynchronously. The first packet after release
//    lands at slot 0.
// CONFIGURATION
//  IQ_PERF_CNT_EN defined:
//   - Adds output stall_cycles [31:0].
//   - Increments each cycle in which any in_valid=1 and in_ready=0.
//   - Saturates at 32'hFFFF_FFFF. Cleared by rst_n only; flush does not clear it.
//  IQ_PERF_CNT_EN undefined: no port and no counter logic. Function is otherwise identical.
// TESTING
//  1 Enq 0x1,0x2,0x3,0x4 (all valid) into empty -> next cycle count=4, out_op_a=0x1,
//    out_op_b=0x2, both valids=1.
//  2 Fill to count=13, offer 4 ops -> in_ready=0, count stays 13.
//    Pop 1 -> count=12, in_ready=1, then the 4 ops are taken -> count=16.
//  3 Wrap: head=tail=14 (empty), enq 0xA..0xD -> slots 14,15,0,1.
//    Pop 2/cycle yields 0xA,0xB then 0xC,0xD; count returns to 0.
//  4 count=5, enq 3 (A,B,C) + accept_a&accept_b same cycle -> count=6,
//    order preserved on the following pops.
//  5 count=7, flush=1 with enq 4 and accept_a -> next cycle count=0,
//    out_valid_a=0, in_ready=1.
//  6 count=6, drop rst_n mid-cycle -> count=0, out_valid_a=0 without a clock edge.
//    With IQ_PERF_CNT_EN, 3 stalled cycles beforehand -> stall_cycles=3, then 0 after reset.

Source files
------------

// File: rtl/instruction_queue_if.sv
// Issue-queue bundle: upstream enqueue lanes A..D and the two-wide issue window.
// master = the side that drives ops and accepts (front-end / issue); slave = the queue.
interface instruction_queue_if #(
    parameter int WIDTH = 57,
    parameter int CNT_W = 5
);
    logic [WIDTH-1:0] in_op_a;
    logic [WIDTH-1:0] in_op_b;
    logic [WIDTH-1:0] in_op_c;
    logic [WIDTH-1:0] in_op_d;
    logic             in_valid_a;
    logic             in_valid_b;
    logic             in_valid_c;
    logic             in_valid_d;
    logic             in_ready;
    logic [WIDTH-1:0] out_op_a;
    logic             out_valid_a;
    logic [WIDTH-1:0] out_op_b;
    logic             out_valid_b;
    logic             out_accept_a;
    logic             out_accept_b;
    logic [CNT_W-1:0] count;

    modport master (
        output in_op_a, in_op_b, in_op_c, in_op_d,
        output in_valid_a, in_valid_b, in_valid_c, in_valid_d,
        output out_accept_a, out_accept_b,
        input  in_ready, out_op_a, out_valid_a, out_op_b, out_valid_b, count
    );

    modport slave (
        input  in_op_a, in_op_b, in_op_c, in_op_d,
        input  in_valid_a, in_valid_b, in_valid_c, in_valid_d,
        input  out_accept_a, out_accept_b,
        output in_ready, out_op_a, out_valid_a, out_op_b, out_valid_b, count
    );
endinterface

// File: rtl/instruction_queue.sv
// instruction_queue: circular FIFO of compacted decode ops. Accepts up to 4 ops/cycle
// (lanes A..D, packed from A), presents the 2 oldest entries, pops 0..2 per cycle.
// Optional feature macro: IQ_PERF_CNT_EN adds a saturating 32-bit stall_cycles counter.
module instruction_queue #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    instruction_queue_if.slave q
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [WIDTH-1:0] w_lane_op  [4];
    logic [3:0]       w_lane_vld;
    logic [2:0]       w_enq_n;
    logic [2:0]       w_enq_eff;
    logic [1:0]       w_deq_n;
    logic             w_in_ready;
    logic             w_valid_a;
    logic             w_valid_b;
    logic             w_gap;
    logic [3:0]       w_wr_en;
    logic [PTR_W-1:0] w_wr_addr [4];
    logic [CNT_W-1:0] w_count_next;

    assign w_lane_op[0] = q.in_op_a;
    assign w_lane_op[1] = q.in_op_b;
    assign w_lane_op[2] = q.in_op_c;
    assign w_lane_op[3] = q.in_op_d;
    assign w_lane_vld   = {q.in_valid_d, q.in_valid_c, q.in_valid_b, q.in_valid_a};

    // Room for a full 4-wide packet, judged from registered occupancy only (same-cycle pops don't count)
    assign w_in_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(4);
    assign w_valid_a  = (r_count != '0);
    assign w_valid_b  = (r_count >= CNT_W'(2));

    // Enqueue count = leading run of valids from lane A; anything after a gap is ignored
    always_comb begin
        w_enq_n = 3'd0;
        if (w_lane_vld[0]) begin
            w_enq_n = 3'd1;
            if (w_lane_vld[1]) begin
                w_enq_n = 3'd2;
                if (w_lane_vld[2]) begin
                    w_enq_n = 3'd3;
                    if (w_lane_vld[3]) begin
                        w_enq_n = 3'd4;
                    end
                end
            end
        end
    end

    assign w_enq_eff = w_in_ready ? w_enq_n : 3'd0;
    assign w_gap = (!w_lane_vld[0] && (w_lane_vld[1] || w_lane_vld[2] || w_lane_vld[3])) ||
                   (!w_lane_vld[1] && (w_lane_vld[2] || w_lane_vld[3])) ||
                   (!w_lane_vld[2] && w_lane_vld[3]);

    // Pop count: B only goes with A, and each accept needs its matching valid
    always_comb begin
        w_deq_n = 2'd0;
        if (q.out_accept_a && w_valid_a) begin
            w_deq_n = (q.out_accept_b && w_valid_b) ? 2'd2 : 2'd1;
        end
    end

    assign w_count_next = r_count + CNT_W'(w_enq_eff) - CNT_W'(w_deq_n);

    // Per-lane write enable and slot address; the tail add wraps naturally in PTR_W bits
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wr_en[gi]   = w_in_ready && (w_enq_n > 3'(gi));
            assign w_wr_addr[gi] = r_tail + PTR_W'(gi);
        end
    endgenerate

    // Storage write; memory contents are intentionally left unreset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_addr[i]] <= w_lane_op[i];
            end
        end
    end

    // Head/tail/count update; flush wins over any same-cycle enqueue or dequeue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_n);
            r_tail  <= r_tail + PTR_W'(w_enq_eff);
            r_count <= w_count_next;
        end
    end

    assign q.in_ready    = w_in_ready;
    assign q.out_valid_a = w_valid_a;
    assign q.out_valid_b = w_valid_b;
    assign q.out_op_a    = r_mem[r_head];
    assign q.out_op_b    = r_mem[r_head + PTR_W'(1)];
    assign q.count       = r_count;

`ifdef IQ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // Count cycles where upstream offers ops but the queue cannot take them; saturating, reset-only clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if ((|w_lane_vld) && !w_in_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    a_no_lane_gap: assert property (@(posedge clk) disable iff (!rst_n) !w_gap);

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: stimulus pushes expected ops into a scoreboard,
// a negedge monitor pops and compares whenever the DUT hands an op to issue.
module tb_instruction_queue;

    localparam int WIDTH = 57;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int n_tests = 0;
    int n_fail  = 0;
    int mdl_cnt = 0;
    int exp_stall = 0;
    logic [WIDTH-1:0] sb_q[$];

    instruction_queue_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) q_if ();

`ifdef IQ_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    instruction_queue #(.WIDTH(WIDTH), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .q     (q_if)
`ifdef IQ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", nm, act);
        end
    endtask

    // Monitor: every op the DUT hands over must match the oldest expected op
    always @(negedge clk) begin
        if (rst_n && q_if.out_accept_a && q_if.out_valid_a) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL pop_a: got %0h expected <none>", q_if.out_op_a);
            end else begin
                if (q_if.out_op_a !== sb_q[0]) begin
                    n_fail++;
                    $display("[TB] FAIL pop_a: got %0h expected %0h", q_if.out_op_a, sb_q[0]);
                end else begin
                    $display("[TB] pop  A %0h", q_if.out_op_a);
                end
                void'(sb_q.pop_front());
            end
            if (q_if.out_accept_b && q_if.out_valid_b) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL pop_b: got %0h expected <none>", q_if.out_op_b);
                end else begin
                    if (q_if.out_op_b !== sb_q[0]) begin
                        n_fail++;
                        $display("[TB] FAIL pop_b: got %0h expected %0h", q_if.out_op_b, sb_q[0]);
                    end else begin
                        $display("[TB] pop  B %0h", q_if.out_op_b);
                    end
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic clear_inputs();
        q_if.in_valid_a = 1'b0; q_if.in_valid_b = 1'b0;
        q_if.in_valid_c = 1'b0; q_if.in_valid_d = 1'b0;
        q_if.in_op_a = '0; q_if.in_op_b = '0; q_if.in_op_c = '0; q_if.in_op_d = '0;
        q_if.out_accept_a = 1'b0; q_if.out_accept_b = 1'b0;
        flush = 1'b0;
    endtask

    // One clock of stimulus: nv packed lanes, accepts, flush; expected ops pushed when they will be taken
    task automatic step(input int nv, input logic [WIDTH-1:0] o0, input logic [WIDTH-1:0] o1,
                        input logic [WIDTH-1:0] o2, input logic [WIDTH-1:0] o3,
                        input bit aa, input bit ab, input bit fl);
        logic [WIDTH-1:0] ops [4];
        bit rdy;
        int deq;
        ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3;
        q_if.in_op_a = o0; q_if.in_op_b = o1; q_if.in_op_c = o2; q_if.in_op_d = o3;
        q_if.in_valid_a = (nv > 0); q_if.in_valid_b = (nv > 1);
        q_if.in_valid_c = (nv > 2); q_if.in_valid_d = (nv > 3);
        q_if.out_accept_a = aa; q_if.out_accept_b = ab;
        flush = fl;
        rdy = ((16 - mdl_cnt) >= 4);
        deq = (aa && mdl_cnt >= 1) ? ((ab && mdl_cnt >= 2) ? 2 : 1) : 0;
        if (nv > 0 && !rdy) exp_stall++;
        if (fl) begin
            mdl_cnt = 0;
        end else begin
            mdl_cnt = mdl_cnt + (rdy ? nv : 0) - deq;
            if (rdy) begin
                for (int i = 0; i < nv; i++) sb_q.push_back(ops[i]);
            end
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic pop2();
        step(0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        v = 57'h100;
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_count", q_if.count, 0);
        chk("rst_in_ready", q_if.in_ready, 1);
        chk("rst_valid_a", q_if.out_valid_a, 0);
        chk("rst_valid_b", q_if.out_valid_b, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: four ops into empty queue
        step(4, 57'h1, 57'h2, 57'h3, 57'h4, 1'b0, 1'b0, 1'b0);
        chk("t1_count", q_if.count, 4);
        chk("t1_op_a", q_if.out_op_a, 57'h1);
        chk("t1_op_b", q_if.out_op_b, 57'h2);
        chk("t1_valid_a", q_if.out_valid_a, 1);
        chk("t1_valid_b", q_if.out_valid_b, 1);
        pop2(); pop2();
        chk("t1_drained", q_if.count, 0);

        // 2: backpressure at 13, single pop reopens, then fill to full
        for (int k = 0; k < 3; k++) begin
            step(4, v, v + 1, v + 2, v + 3, 1'b0, 1'b0, 1'b0);
            v = v + 4;
        end
        step(1, v, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        v = v + 1;
        chk("t2_count13", q_if.count, 13);
        chk("t2_not_ready", q_if.in_ready, 0);
        step(4, 57'h40, 57'h41, 57'h42, 57'h43, 1'b0, 1'b0, 1'b0);
        chk("t2_hold13", q_if.count, 13);
        step(4, 57'h40, 57'h41, 57'h42, 57'h43, 1'b0, 1'b0, 1'b0);
        step(4, 57'h40, 57'h41, 57'h42, 57'h43, 1'b1, 1'b0, 1'b0);
        chk("t2_count12", q_if.count, 12);
        chk("t2_ready", q_if.in_ready, 1);
        step(4, 57'h40, 57'h41, 57'h42, 57'h43, 1'b0, 1'b0, 1'b0);
        chk("t2_full", q_if.count, 16);
        chk("t2_full_ready", q_if.in_ready, 0);
        chk("t2_full_valid_b", q_if.out_valid_b, 1);
        for (int k = 0; k < 8; k++) pop2();
        chk("t2_empty", q_if.count, 0);

        // 3: move pointers to 14 then enqueue across the wrap
        step(4, v, v + 1, v + 2, v + 3, 1'b0, 1'b0, 1'b0); v = v + 4;
        step(4, v, v + 1, v + 2, v + 3, 1'b0, 1'b0, 1'b0); v = v + 4;
        step(1, v, '0, '0, '0, 1'b0, 1'b0, 1'b0); v = v + 1;
        for (int k = 0; k < 4; k++) pop2();
        step(0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t3_empty14", q_if.count, 0);
        step(4, 57'hA, 57'hB, 57'hC, 57'hD, 1'b0, 1'b0, 1'b0);
        chk("t3_count", q_if.count, 4);
        chk("t3_op_a", q_if.out_op_a, 57'hA);
        chk("t3_op_b", q_if.out_op_b, 57'hB);
        pop2(); pop2();
        chk("t3_drained", q_if.count, 0);

        // 4: enqueue 3 and pop 2 in the same cycle
        step(4, v, v + 1, v + 2, v + 3, 1'b0, 1'b0, 1'b0); v = v + 4;
        step(1, v, '0, '0, '0, 1'b0, 1'b0, 1'b0); v = v + 1;
        chk("t4_count5", q_if.count, 5);
        step(3, 57'h51, 57'h52, 57'h53, '0, 1'b1, 1'b1, 1'b0);
        chk("t4_count6", q_if.count, 6);
        pop2(); pop2(); pop2();
        chk("t4_drained", q_if.count, 0);

        // 5: flush overrides enqueue and dequeue
        step(4, v, v + 1, v + 2, v + 3, 1'b0, 1'b0, 1'b0); v = v + 4;
        step(3, v, v + 1, v + 2, '0, 1'b0, 1'b0, 1'b0); v = v + 3;
        chk("t5_count7", q_if.count, 7);
        step(4, 57'h61, 57'h62, 57'h63, 57'h64, 1'b1, 1'b0, 1'b1);
        sb_q.delete();
        chk("t5_count", q_if.count, 0);
        chk("t5_valid_a", q_if.out_valid_a, 0);
        chk("t5_ready", q_if.in_ready, 1);

        // 6: asynchronous reset with entries present
        step(4, v, v + 1, v + 2, v + 3, 1'b0, 1'b0, 1'b0); v = v + 4;
        step(2, v, v + 1, '0, '0, 1'b0, 1'b0, 1'b0); v = v + 2;
        chk("t6_count6", q_if.count, 6);
`ifdef IQ_PERF_CNT_EN
        chk("t6_stall_pre", stall_cycles, 64'(exp_stall));
        chk("t6_stall_3", stall_cycles, 3);
`endif
        rst_n = 1'b0;
        #2;
        chk("t6_count", q_if.count, 0);
        chk("t6_valid_a", q_if.out_valid_a, 0);
        chk("t6_ready", q_if.in_ready, 1);
`ifdef IQ_PERF_CNT_EN
        chk("t6_stall_rst", stall_cycles, 0);
`endif
        sb_q.delete();
        mdl_cnt = 0;
        exp_stall = 0;
        #5;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 57'h77, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("t6_post_count", q_if.count, 1);
        chk("t6_post_op_a", q_if.out_op_a, 57'h77);
        step(0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t6_post_empty", q_if.count, 0);
        chk("sb_empty", 64'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
